mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single l2cache memory port between the two pipeline requesters: port 0 is instruction fetch, port 1 is the load/store unit.
- It sits between the fetch/memory stages and the l2cache, replacing the dual-port bus with one arbitrated port.
- At most one transaction is outstanding at any time.
- Data port has fixed priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive port-1 grants that fetch may lose while requesting before fetch is forced to win; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  2  per-port request valid; bit0 = fetch, bit1 = memory
req_ready  output  2  per-port request accepted (handshake completes when valid & ready)
req_addr  input  2*ADDR_W  per-port address; port i at bits [i*ADDR_W +: ADDR_W]
req_we  input  2  per-port write enable
req_wdata  input  2*DATA_W  per-port write data
req_wstrb  input  2*(DATA_W/8)  per-port byte strobes
resp_valid  output  2  per-port response pulse
resp_rdata  output  DATA_W  read data, broadcast to both ports
mem_req_valid  output  1  downstream request valid
mem_req_ready  input  1  downstream accepts request
mem_addr  output  ADDR_W  downstream address
mem_we  output  1  downstream write enable
mem_wdata  output  DATA_W  downstream write data
mem_wstrb  output  DATA_W/8  downstream byte strobes
mem_resp_valid  input  1  downstream response (reads and writes)
mem_resp_rdata  input  DATA_W  downstream read data
busy  output  1  transaction in progress (state != IDLE)
error  output  1  sticky protocol error

Behaviour:

Reset and clocking:
- One clock, clk. Reset rst is synchronous, active-high.
- On reset: state = IDLE; grant = 0; starve_cnt = 0; latched request fields = 0; error = 0.
- Consequently, in the cycle after reset: mem_req_valid = 0, mem_addr/mem_we/mem_wdata/mem_wstrb = 0, busy = 0, req_ready = 0, resp_valid = 0.
- Reset mid-transaction abandons the transaction; no response is delivered to either port.

FSM states: IDLE, ISSUE, WAIT.

IDLE:
- Grant port 1 if req_valid[1] = 1 and NOT (req_valid[0] = 1 and starve_cnt >= STARVE_LIMIT).
- Otherwise grant port 0 if req_valid[0] = 1.
- If no port is granted, stay in IDLE.
- req_ready[g] is combinational and is 1 only in IDLE, only for the granted port g; the other port sees 0.
- On a grant: latch addr/we/wdata/wstrb of port g and register g; next state = ISSUE.

starve_cnt (updated at each grant decision):
- Grant to port 1 while req_valid[0] = 1: increment, saturating at STARVE_LIMIT.
- Grant to port 0: clear to 0.
- Grant to port 1 with req_valid[0] = 0: clear to 0.

ISSUE:
- mem_req_valid = 1; mem_* outputs drive the latched fields and stay stable until accepted.
- When mem_req_ready = 1: next state = WAIT.

WAIT:
- resp_valid[g] = mem_resp_valid, combinationally; resp_valid of the other port is 0.
- resp_rdata = mem_resp_rdata at all times.
- On mem_resp_valid = 1: next state = IDLE.
- Write transactions also complete on mem_resp_valid.

Latency:
- Request accepted in cycle N.
- mem_req_valid rises in cycle N+1.
- Response is returned in the same cycle it arrives downstream.
- A new grant is possible in the cycle after the response.
- Minimum request-to-request spacing: 3 cycles.

Error:
- error is set when mem_resp_valid = 1 while state != WAIT.
- error stays set until reset; the stray response is dropped.

Boundary conditions:
- req_valid may drop without a handshake; the arbiter takes no action.
- Simultaneous response and new request: the new request waits until IDLE.
- mem_req_ready while not in ISSUE is ignored.

Test Plan:
- Single read on port 0: addr 0x100; mem_req_ready = 1 immediately; response 0xDEADBEEF 2 cycles later -> req_ready[0] in cycle 0; mem_req_valid with addr 0x100 in cycle 1; resp_valid[0] with rdata 0xDEADBEEF in cycle 3; resp_valid[1] = 0 throughout.
- Both ports request at once: port 1 write addr 0x200, wdata 0x55, wstrb 0xF -> port 1 granted first; port 0 is granted in the first IDLE cycle after the port-1 response.
- Starvation, STARVE_LIMIT = 4: both ports request continuously -> grant sequence 1,1,1,1,0,1,1,1,1,0.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid, mem_addr and mem_wdata stay stable for all 5 cycles; no req_ready is asserted during that time.
- Stray mem_resp_valid while in IDLE -> error = 1 and stays high; no resp_valid on either port; rst clears error.
- rst asserted while in WAIT -> next cycle: state IDLE, busy = 0; a later response sets error.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and l2cache-side signals for mem_arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2*ADDR_W-1:0]   req_addr;
  logic [1:0]            req_we;
  logic [2*DATA_W-1:0]   req_wdata;
  logic [2*DATA_W/8-1:0] req_wstrb;
  logic [1:0]            resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_resp_rdata;

  modport slave (
    input  req_valid, req_addr, req_we,
    input  req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_addr, mem_we,
    output mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_rdata
  );

  modport master (
    output req_valid, req_addr, req_we,
    output req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_addr, mem_we,
    input  mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port to one-port l2cache arbiter, one outstanding transaction.
// Load/store wins by default; fetch is forced through after repeated losses.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          error
);

  localparam int SW = DATA_W / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              err_q, err_d;
  logic              win1, win0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bus.req_ready     = 2'b00;
    bus.resp_valid    = 2'b00;
    bus.mem_req_valid = 1'b0;

    // fetch overrides only once it has lost LIM grants in a row
    win1 = bus.req_valid[1] &&
           !(bus.req_valid[0] && starve_q >= LIM);
    win0 = !win1 && bus.req_valid[0];

    unique case (state_q)
      IDLE: begin
        if (win1 || win0) begin
          bus.req_ready[win1] = 1'b1;
          gnt_d   = win1;
          state_d = ISSUE;
          if (win1) begin
            addr_d  = bus.req_addr[2*ADDR_W-1:ADDR_W];
            we_d    = bus.req_we[1];
            wdata_d = bus.req_wdata[2*DATA_W-1:DATA_W];
            wstrb_d = bus.req_wstrb[2*SW-1:SW];
          end else begin
            addr_d  = bus.req_addr[ADDR_W-1:0];
            we_d    = bus.req_we[0];
            wdata_d = bus.req_wdata[DATA_W-1:0];
            wstrb_d = bus.req_wstrb[SW-1:0];
          end
          if (win1 && bus.req_valid[0])
            starve_d = (starve_q >= LIM) ? LIM
                                         : starve_q + 4'd1;
          else
            starve_d = '0;
        end
      end
      ISSUE: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        bus.resp_valid[gnt_q] = bus.mem_resp_valid;
        if (bus.mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q ||
            (bus.mem_resp_valid && state_q != WAIT);
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.resp_rdata = bus.mem_resp_rdata;
  assign busy           = (state_q != IDLE);
  assign error          = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table,
// starvation sequence and randomized run against a transaction model.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic error;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy),
    .error(error)
  );

  typedef struct {
    logic        rst, chk;
    logic [1:0]  rv;
    logic [31:0] a0, a1;
    logic [1:0]  we;
    logic [31:0] wd1;
    logic [3:0]  ws1;
    logic        mrr, mrsp;
    logic [31:0] mrd;
    logic [1:0]  e_rdy;
    logic        e_mrv;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wd;
    logic [1:0]  e_rsp;
    logic        e_busy, e_err;
  } vec_t;

  function automatic vec_t v(
    logic r, logic c, logic [1:0] rv,
    logic [31:0] a0, logic [31:0] a1,
    logic [1:0] we, logic [31:0] wd1,
    logic [3:0] ws1, logic mrr, logic mrsp,
    logic [31:0] mrd, logic [1:0] e_rdy,
    logic e_mrv, logic [31:0] e_addr,
    logic e_we, logic [31:0] e_wd,
    logic [1:0] e_rsp, logic e_busy,
    logic e_err);
    vec_t t;
    t.rst = r; t.chk = c; t.rv = rv;
    t.a0 = a0; t.a1 = a1; t.we = we;
    t.wd1 = wd1; t.ws1 = ws1;
    t.mrr = mrr; t.mrsp = mrsp; t.mrd = mrd;
    t.e_rdy = e_rdy; t.e_mrv = e_mrv;
    t.e_addr = e_addr; t.e_we = e_we;
    t.e_wd = e_wd; t.e_rsp = e_rsp;
    t.e_busy = e_busy; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, a, e, $time);
    end
  endtask

  task automatic idle_in();
    bus.req_valid      = '0;
    bus.req_addr       = '0;
    bus.req_we         = '0;
    bus.req_wdata      = '0;
    bus.req_wstrb      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vt[$];

  task automatic run_table();
    foreach (vt[i]) begin
      @(negedge clk);
      rst                = vt[i].rst;
      bus.req_valid      = vt[i].rv;
      bus.req_addr       = {vt[i].a1, vt[i].a0};
      bus.req_we         = vt[i].we;
      bus.req_wdata      = {vt[i].wd1, 32'h0};
      bus.req_wstrb      = {vt[i].ws1, 4'h0};
      bus.mem_req_ready  = vt[i].mrr;
      bus.mem_resp_valid = vt[i].mrsp;
      bus.mem_resp_rdata = vt[i].mrd;
      #1;
      if (vt[i].chk) begin
        chk($sformatf("v%0d.rdy", i),
            64'(bus.req_ready), 64'(vt[i].e_rdy));
        chk($sformatf("v%0d.mrv", i),
            64'(bus.mem_req_valid), 64'(vt[i].e_mrv));
        chk($sformatf("v%0d.rsp", i),
            64'(bus.resp_valid), 64'(vt[i].e_rsp));
        chk($sformatf("v%0d.busy", i),
            64'(busy), 64'(vt[i].e_busy));
        chk($sformatf("v%0d.err", i),
            64'(error), 64'(vt[i].e_err));
        if (vt[i].e_rsp != 2'b00)
          chk($sformatf("v%0d.rdata", i),
              64'(bus.resp_rdata), 64'(vt[i].mrd));
        if (vt[i].e_mrv) begin
          chk($sformatf("v%0d.addr", i),
              64'(bus.mem_addr), 64'(vt[i].e_addr));
          chk($sformatf("v%0d.we", i),
              64'(bus.mem_we), 64'(vt[i].e_we));
          chk($sformatf("v%0d.wdata", i),
              64'(bus.mem_wdata), 64'(vt[i].e_wd));
        end
      end
    end
  endtask

  // Fetch and LSU both request nonstop; each transaction takes 3 cycles.
  task automatic run_starve();
    int exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int got;
    do_reset();
    #1;
    chk("rst.addr", 64'(bus.mem_addr), 64'h0);
    chk("rst.wstrb", 64'(bus.mem_wstrb), 64'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid     = 2'b11;
      bus.req_addr      = {32'h2000 + k, 32'h1000 + k};
      bus.mem_req_ready = 1'b1;
      bus.mem_resp_valid = 1'b0;
      #1;
      case (bus.req_ready)
        2'b01:   got = 0;
        2'b10:   got = 1;
        default: got = 2;
      endcase
      chk($sformatf("starve.g%0d", k),
          64'(got), 64'(exp_g[k]));
      @(negedge clk);
      @(negedge clk);
      bus.mem_resp_valid = 1'b1;
    end
    @(negedge clk);
    idle_in();
  endtask

  // Transaction-level model: one pending entry, issued or not yet.
  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  task automatic run_random(input int cycles);
    txn_t        q[$];
    bit          issued = 0;
    int          losses = 0;
    int          want;
    logic [1:0]  rv;
    logic [1:0]  e_rdy, e_rsp;
    logic [31:0] a[2], wd[2];
    logic [3:0]  ws[2];
    logic [1:0]  we;
    txn_t        t;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rv = 2'($urandom);
      we = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        a[p]  = $urandom;
        wd[p] = $urandom;
        ws[p] = 4'($urandom);
      end
      bus.req_valid = rv;
      bus.req_we    = we;
      bus.req_addr  = {a[1], a[0]};
      bus.req_wdata = {wd[1], wd[0]};
      bus.req_wstrb = {ws[1], ws[0]};
      bus.mem_req_ready  = 1'($urandom_range(0, 1));
      bus.mem_resp_valid = (q.size() != 0 && issued)
                         ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus.mem_resp_rdata = $urandom;
      #1;
      want = -1;
      if (q.size() == 0) begin
        if (rv[1] && !(rv[0] && losses >= LIM)) want = 1;
        else if (rv[0]) want = 0;
      end
      e_rdy = (want < 0) ? 2'b00 : 2'(1 << want);
      e_rsp = 2'b00;
      if (q.size() != 0 && issued && bus.mem_resp_valid)
        e_rsp = 2'(1 << q[0].port);
      chk("rnd.rdy", 64'(bus.req_ready), 64'(e_rdy));
      chk("rnd.rsp", 64'(bus.resp_valid), 64'(e_rsp));
      chk("rnd.mrv", 64'(bus.mem_req_valid),
          64'(q.size() != 0 && !issued));
      chk("rnd.busy", 64'(busy), 64'(q.size() != 0));
      chk("rnd.err", 64'(error), 64'h0);
      chk("rnd.rdata", 64'(bus.resp_rdata),
          64'(bus.mem_resp_rdata));
      if (q.size() != 0 && !issued)
        chk("rnd.req", {bus.mem_addr, bus.mem_wdata},
            {q[0].addr, q[0].wdata});
      if (q.size() != 0 && !issued)
        chk("rnd.ctl", 64'({bus.mem_we, bus.mem_wstrb}),
            64'({q[0].we, q[0].wstrb}));
      if (want >= 0) begin
        t.port = want; t.addr = a[want];
        t.we = we[want]; t.wdata = wd[want];
        t.wstrb = ws[want];
        q.push_back(t);
        issued = 0;
        losses = (want == 1 && rv[0])
               ? ((losses >= LIM) ? LIM : losses + 1) : 0;
      end else if (q.size() != 0 && !issued) begin
        if (bus.mem_req_ready) issued = 1;
      end else if (q.size() != 0 && bus.mem_resp_valid) begin
        void'(q.pop_front());
      end
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    vt.push_back(v(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,2'b01,'h100,0,0,0,0,1,0,0,
                   2'b01,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,1,0,0,
                   0,1,'h100,0,0,0,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,1,'hDEADBEEF,
                   0,0,0,0,0,2'b01,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,2'b11,'h300,'h200,2'b10,'h55,'hF,0,0,0,
                   2'b10,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,2'b01,'h300,0,0,0,0,1,0,0,
                   0,1,'h200,1,'h55,0,1,0));
    vt.push_back(v(0,1,2'b01,'h300,0,0,0,0,0,1,'h0BADF00D,
                   0,0,0,0,0,2'b10,1,0));
    vt.push_back(v(0,1,2'b01,'h300,0,0,0,0,0,0,0,
                   2'b01,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,1,0,0,
                   0,1,'h300,0,0,0,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,1,'h12345678,
                   0,0,0,0,0,2'b01,1,0));
    vt.push_back(v(0,1,2'b10,0,'h400,2'b10,'hA5A5,'h3,0,0,0,
                   2'b10,0,0,0,0,0,0,0));
    for (int s = 0; s < 5; s++)
      vt.push_back(v(0,1,2'b11,0,'h999,2'b10,'h1111,'hF,0,0,0,
                     0,1,'h400,1,'hA5A5,0,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,1,0,0,
                   0,1,'h400,1,'hA5A5,0,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,1,'hCAFE,
                   0,0,0,0,0,2'b10,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,1,'h77, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vt.push_back(v(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,2'b01,'h500,0,0,0,0,0,0,0,
                   2'b01,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,1,0,0,
                   0,1,'h500,0,0,0,1,0));
    vt.push_back(v(1,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,1,'h99, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vt.push_back(v(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));

    run_table();
    run_starve();
    run_random(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
